sdp_ram_fifo: RTL and testbench
===============================

Name: sdp_ram_fifo

Overview:
Synchronous first-word-fall-through FIFO that drives a simple dual-port RAM as its initiator. Writes go through the RAM write port. Reads go through the registered-address read port, whose data is valid one cycle after the address is captured. A 2-entry landing buffer hides that read latency so the output sustains one word per cycle. It sits between streaming producers and consumers wherever RAM-backed buffering is required.

Parameters:
DATA_WIDTH, 14, word width.
ADDR_WIDTH, 6, RAM address width; DEPTH = 2**ADDR_WIDTH (derived localparam, not overridable).

Ports:
clk  input  1  single clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_data  input  DATA_WIDTH  push data.
in_valid  input  1  push request.
in_ready  output  1  push accepted when in_valid && in_ready.
out_data  output  DATA_WIDTH  head-of-FIFO word.
out_valid  output  1  out_data is valid.
out_ready  input  1  pop when out_valid && out_ready.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- State:
  - wr_ptr, rd_ptr: ADDR_WIDTH bits each, wrap naturally modulo DEPTH.
  - ram_count: ADDR_WIDTH+1 bits, range 0..DEPTH.
  - rd_pend: 1 bit.
  - Landing buffer: 2 entries, with head index and buf_count (0..2).
- Reset values, effective on rst_n low without waiting for clk:
  - All pointers, counts and rd_pend clear to 0.
  - Buffer entries clear to 0.
  - out_valid=0, out_data=0.
  - in_ready=1, because it derives from ram_count.
  - RAM contents are not reset.
  - Pushes are ignored while rst_n is low.
  - Reset mid-operation discards every stored and in-flight word. The first word after release is the first word pushed after release.
- Push:
  - in_ready = (ram_count != DEPTH).
  - On a handshake: RAM write_en=1, addr=wr_ptr, data=in_data; wr_ptr++.
- Read issue, evaluated on each edge:
  - Condition: ram_count>0 && (buf_count + rd_pend - pop) < 2, where pop = out_valid && out_ready.
  - On issue: present rd_ptr to the RAM read address; rd_ptr++; set rd_pend.
  - rd_pend clears the following edge unless a new read is issued on that edge.
  - ram_count += push - issue, on the same edge.
- Landing: when rd_pend=1, RAM dout is written into the buffer tail on the next edge.
- Output:
  - out_valid = (buf_count != 0).
  - out_data = buffer[head].
  - On a pop, head advances.
  - buf_count += land - pop.
- Latency: push handshake in cycle k gives out_valid in cycle k+3 when the FIFO was empty.
- Throughput: one word per cycle in steady state with out_ready held high.
- Capacity: DEPTH words in RAM plus 2 in the buffer, DEPTH+2 total. in_ready drops only when RAM is full.
- Read/write address collision cannot occur:
  - Reads issue only from entries already committed (ram_count>0, registered).
  - A write when wr_ptr==rd_ptr requires ram_count==DEPTH, where in_ready=0.
- Simultaneous push and pop when ram_count=0: both are accepted; counts stay consistent.
- Ordering is strictly FIFO across pointer wrap.

Optional Feature:
SDP_RAM_FIFO_LEVEL_EN:
- Defined: adds output `level` [ADDR_WIDTH+1:0] = ram_count + rd_pend + buf_count, registered-state derived, reset 0, max DEPTH+2.
- Undefined: the port and its logic are absent; nothing else changes.

Decomposition:
- Package sdp_ram_fifo_pkg:
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - BUF_ENTRIES=2 constant;
  - typedefs data_t, addr_t, count_t.
- Sub-module sdp_ram_fifo_mem:
  - reg array of DEPTH words, no reset, no init file;
  - write port: write_en/addr/data_in;
  - read port: address registered on clk, data_out combinationally from the registered address (1-cycle read latency).
- The FIFO instantiates exactly one sdp_ram_fifo_mem.

Test Plan:
- Reset, then push 0x0001 in cycle 10 with out_ready=1 -> out_valid=1, out_data=0x0001 in cycle 13; popped that cycle; out_valid=0 in cycle 14.
- out_ready=0, in_valid=1 continuously with data 0..N -> exactly 66 words accepted (DEPTH=64), then in_ready=0; raise out_ready -> 0..65 emerge in order; in_ready returns 1 once ram_count<64.
- in_valid=1 and out_ready=1 continuously for 200 words -> after the initial 3-cycle fill, out_valid stays 1 every cycle; data matches in order across three pointer wraps.
- Random in_valid/out_ready (50% each) for 5000 cycles -> scoreboard match; no pop while out_valid=0; no write while in_ready=0.
- Fill 20 words, assert rst_n low mid-stream (not clock-aligned) -> out_valid=0, out_data=0, in_ready=1 immediately; after release, push 0x3FFF -> 0x3FFF is the next word out.
- With SDP_RAM_FIFO_LEVEL_EN: push 5 with out_ready=0 -> level=5 once settled; pop 1 -> level=4.

Source files
------------

// File: rtl/sdp_ram_fifo_pkg.sv
// Shared constants and types for the RAM-backed FWFT FIFO.
package sdp_ram_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 14;
    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned BUF_ENTRIES    = 2;

    typedef logic [DEF_DATA_WIDTH-1:0] data_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_ADDR_WIDTH:0]   count_t;

endpackage

// File: rtl/sdp_ram_fifo_if.sv
// Push/pop streaming handshake bundle for sdp_ram_fifo.
interface sdp_ram_fifo_if
    import sdp_ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/sdp_ram_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read address, 1-cycle read latency.
module sdp_ram_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 14,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_addr_q <= rd_addr_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_q];

endmodule

// File: rtl/sdp_ram_fifo.sv
// First-word-fall-through FIFO over a simple dual-port RAM with a 2-entry landing buffer.
// Optional occupancy output enabled by defining SDP_RAM_FIFO_LEVEL_EN.
module sdp_ram_fifo
    import sdp_ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef SDP_RAM_FIFO_LEVEL_EN
    output logic [ADDR_WIDTH+1:0] level,
`endif
    sdp_ram_fifo_if.slave         bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] buf_q [BUF_ENTRIES];
    logic [DATA_WIDTH-1:0] buf_d [BUF_ENTRIES];
    logic                  head_q, head_d;
    logic [1:0]            buf_count_q, buf_count_d;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  land;
    logic                  tail;
    logic [2:0]            occ;
    logic [DATA_WIDTH-1:0] rd_data;

    assign bus.in_ready  = (ram_count_q != FULL_COUNT);
    assign bus.out_valid = (buf_count_q != 2'd0);
    assign bus.out_data  = buf_q[head_q];

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    assign land = rd_pend_q;
    assign tail = head_q ^ buf_count_q[0];

    // Buffer slots already spoken for after this edge; a read may issue only if one stays free.
    assign occ   = {1'b0, buf_count_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign issue = (ram_count_q != '0) && (occ < 3'd2);

    sdp_ram_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk_i    (clk),
        .wr_en_i  (push),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(bus.in_data),
        .rd_en_i  (issue),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(rd_data)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(push);
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(issue);
        ram_count_d = ram_count_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(issue);
        rd_pend_d   = issue;
        head_d      = head_q ^ pop;
        buf_count_d = buf_count_q + {1'b0, land} - {1'b0, pop};
        buf_d       = buf_q;
        if (land) begin
            buf_d[tail] = rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            rd_pend_q   <= 1'b0;
            head_q      <= 1'b0;
            buf_count_q <= '0;
            for (int i = 0; i < int'(BUF_ENTRIES); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            rd_pend_q   <= rd_pend_d;
            head_q      <= head_d;
            buf_count_q <= buf_count_d;
            buf_q       <= buf_d;
        end
    end

`ifdef SDP_RAM_FIFO_LEVEL_EN
    assign level = (ADDR_WIDTH + 2)'(ram_count_q) + (ADDR_WIDTH + 2)'(rd_pend_q)
                 + (ADDR_WIDTH + 2)'(buf_count_q);
`endif

endmodule

// File: tb/tb_sdp_ram_fifo.sv
// Randomized self-checking bench for sdp_ram_fifo against a queue-based reference model.
module tb_sdp_ram_fifo;
    import sdp_ram_fifo_pkg::*;

    localparam int unsigned DW    = DEF_DATA_WIDTH;
    localparam int unsigned AW    = DEF_ADDR_WIDTH;
    localparam int unsigned DEPTH = 2 ** AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sdp_ram_fifo_if #(.DATA_WIDTH(DW)) bus ();

`ifdef SDP_RAM_FIFO_LEVEL_EN
    logic [AW+1:0] level;
`endif

    sdp_ram_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
`ifdef SDP_RAM_FIFO_LEVEL_EN
        .level(level),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    logic [DW-1:0] model_q [$];
    logic          s_push;
    logic          s_out_valid;
    logic [DW-1:0] s_out_data;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // One clock cycle: sample mid-cycle, check against the model, then commit handshakes.
    task automatic tick();
        logic pop;
        @(negedge clk);
        s_push      = bus.in_valid && bus.in_ready;
        pop         = bus.out_valid && bus.out_ready;
        s_out_valid = bus.out_valid;
        s_out_data  = bus.out_data;
        if (bus.out_valid) begin
            if (model_q.size() == 0) check_eq("valid_when_empty", 32'd1, 32'd0);
            else check_eq("out_data", 32'(bus.out_data), 32'(model_q[0]));
        end
        if (model_q.size() < DEPTH) check_eq("in_ready_not_full", 32'(bus.in_ready), 32'd1);
        else if (model_q.size() >= DEPTH + 2) check_eq("in_ready_full", 32'(bus.in_ready), 32'd0);
`ifdef SDP_RAM_FIFO_LEVEL_EN
        check_eq("level_track", 32'(level), model_q.size());
`endif
        @(posedge clk);
        if (pop && model_q.size() != 0) void'(model_q.pop_front());
        if (s_push) model_q.push_back(bus.in_data);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        model_q.delete();
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int unsigned guard;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (model_q.size() != 0 && guard < 400) begin
            tick();
            guard++;
        end
        tick();
        check_eq(tag, model_q.size(), 32'd0);
        check_eq({tag, "_valid"}, 32'(s_out_valid), 32'd0);
    endtask

    initial begin
        int unsigned accepted;
        int unsigned bubbles;
        int unsigned guard;
        logic        seen;
        logic [DW-1:0] first_word;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        check_eq("init_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("init_out_data", 32'(bus.out_data), 32'd0);
        check_eq("init_in_ready", 32'(bus.in_ready), 32'd1);
        do_reset();

        // Single word latency: visible three cycles after the push, gone after the pop.
        bus.out_ready = 1'b1;
        repeat (9) tick();
        bus.in_data  = 14'h0001;
        bus.in_valid = 1'b1;
        tick();
        check_eq("lat_push", 32'(s_push), 32'd1);
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq($sformatf("lat_valid_k%0d", i), 32'(s_out_valid), (i == 3) ? 32'd1 : 32'd0);
            if (i == 3) check_eq("lat_data", 32'(s_out_data), 32'h0001);
        end

        // Capacity: RAM plus landing buffer.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        accepted      = 0;
        bus.in_data   = '0;
        repeat (DEPTH + 20) begin
            tick();
            if (s_push) begin
                accepted++;
                bus.in_data = DW'(accepted);
            end
        end
        check_eq("fill_accepted", accepted, DEPTH + 2);
        check_eq("fill_in_ready", 32'(bus.in_ready), 32'd0);
        drain("fill_drain");

        // Streaming: no bubbles after the initial fill, across several pointer wraps.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        accepted      = 0;
        bubbles       = 0;
        guard         = 0;
        bus.in_data   = DW'(1000);
        while (accepted < 200 && guard < 400) begin
            tick();
            if (guard >= 3 && !s_out_valid) bubbles++;
            if (s_push) begin
                accepted++;
                bus.in_data = DW'(1000 + accepted);
            end
            guard++;
        end
        check_eq("stream_accepted", accepted, 32'd200);
        check_eq("stream_bubbles", bubbles, 32'd0);
        drain("stream_drain");

        // Random handshakes.
        for (int c = 0; c < 5000; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_data   = DW'($urandom);
            tick();
        end
        drain("rand_drain");

        // Reset mid-stream discards everything stored and in flight.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        accepted      = 0;
        while (accepted < 20) begin
            bus.in_data = DW'($urandom);
            tick();
            if (s_push) accepted++;
        end
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 14'h3FFF;
        tick();
        bus.in_valid = 1'b0;
        seen         = 1'b0;
        first_word   = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_out_valid && !seen) begin
                seen       = 1'b1;
                first_word = s_out_data;
            end
        end
        check_eq("post_rst_seen", 32'(seen), 32'd1);
        check_eq("post_rst_word", 32'(first_word), 32'h3FFF);

`ifdef SDP_RAM_FIFO_LEVEL_EN
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        accepted      = 0;
        while (accepted < 5) begin
            bus.in_data = DW'(accepted);
            tick();
            if (s_push) accepted++;
        end
        bus.in_valid = 1'b0;
        repeat (4) tick();
        check_eq("level_5", 32'(level), 32'd5);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check_eq("level_4", 32'(level), 32'd4);
        drain("level_drain");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
